// File: rtl/line_buffer_3row.sv
// Row-alignment stage ahead of the 3x3 convolution core. Two circular line
// memories hold the previous rows so each column leaves as an aligned 3-pixel tap.
module line_buffer_3row #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] pixel_i,
   input  logic                  valid_i,
   output logic [DATA_WIDTH-1:0] fifo1_data_o,
   output logic [DATA_WIDTH-1:0] fifo2_data_o,
   output logic [DATA_WIDTH-1:0] fifo3_data_o,
   output logic                  ready_o,
   output logic                  frame_done_o
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
   localparam logic [RW-1:0] ROW_READY = RW'(2);

   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic [DATA_WIDTH-1:0] fifo1_q, fifo2_q, fifo3_q;
   logic                  ready_q, frameDone_q;

   // line0_q holds row r-1, line1_q holds row r-2 (relative to the incoming row)
   logic [DATA_WIDTH-1:0] line0_q [IMG_WIDTH];
   logic [DATA_WIDTH-1:0] line1_q [IMG_WIDTH];

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (valid_i) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q       <= '0;
         row_q       <= '0;
         fifo1_q     <= '0;
         fifo2_q     <= '0;
         fifo3_q     <= '0;
         ready_q     <= 1'b0;
         frameDone_q <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         ready_q     <= valid_i && (row_q >= ROW_READY);
         frameDone_q <= valid_i && (row_q == ROW_LAST) && (col_q == COL_LAST);
         if (valid_i) begin
            fifo1_q <= line1_q[col_q];
            fifo2_q <= line0_q[col_q];
            fifo3_q <= pixel_i;
         end
      end
   end

   // Memories are never cleared; ready_o gating keeps stale rows from escaping
   always_ff @(posedge clk) begin
      if (!rst && valid_i) begin
         line1_q[col_q] <= line0_q[col_q];
         line0_q[col_q] <= pixel_i;
      end
   end

   assign fifo1_data_o = fifo1_q;
   assign fifo2_data_o = fifo2_q;
   assign fifo3_data_o = fifo3_q;
   assign ready_o      = ready_q;
   assign frame_done_o = frameDone_q;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Scoreboard bench for line_buffer_3row on a 4x4 image: expected columns come
// from a per-frame image model, are queued on drive and compared after the edge.
module tb_line_buffer_3row;

   localparam int DW = 8;
   localparam int W  = 4;
   localparam int H  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] pixelIn;
   logic          validIn;
   logic [DW-1:0] fifo1Out, fifo2Out, fifo3Out;
   logic          readyOut, frameDoneOut;

   typedef struct {
      logic          ready;
      logic          done;
      logic          checkData;
      logic [DW-1:0] f1;
      logic [DW-1:0] f2;
      logic [DW-1:0] f3;
   } expect_t;

   expect_t       sbQ[$];
   int            total = 0;
   int            bad   = 0;
   int            mRow, mCol;
   logic [DW-1:0] img [H][W];
   logic          lastKnown;
   logic [DW-1:0] last1, last2, last3;

   line_buffer_3row #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk          (clk),
      .rst          (rst),
      .pixel_i      (pixelIn),
      .valid_i      (validIn),
      .fifo1_data_o (fifo1Out),
      .fifo2_data_o (fifo2Out),
      .fifo3_data_o (fifo3Out),
      .ready_o      (readyOut),
      .frame_done_o (frameDoneOut)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, wanted %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Drive one cycle; the image model decides what the column should look like
   task automatic applyStimulus(input logic valid, input logic [DW-1:0] pix);
      expect_t e;
      @(negedge clk);
      rst     = 1'b0;
      validIn = valid;
      pixelIn = pix;
      e.ready = 1'b0;
      e.done  = 1'b0;
      if (valid) begin
         e.ready     = (mRow >= 2);
         e.done      = (mRow == H - 1) && (mCol == W - 1);
         e.checkData = (mRow >= 2);
         e.f1        = (mRow >= 2) ? img[mRow-2][mCol] : '0;
         e.f2        = (mRow >= 2) ? img[mRow-1][mCol] : '0;
         e.f3        = pix;
         img[mRow][mCol] = pix;
         lastKnown = e.checkData;
         last1 = e.f1; last2 = e.f2; last3 = e.f3;
         if (mCol == W - 1) begin
            mCol = 0;
            mRow = (mRow == H - 1) ? 0 : mRow + 1;
         end else begin
            mCol++;
         end
      end else begin
         e.checkData = lastKnown;
         e.f1 = last1; e.f2 = last2; e.f3 = last3;
      end
      sbQ.push_back(e);
      @(posedge clk);
      #1;
      e = sbQ.pop_front();
      checkOutput("ready", 32'(readyOut), 32'(e.ready));
      checkOutput("frameDone", 32'(frameDoneOut), 32'(e.done));
      if (e.checkData) begin
         checkOutput("fifo1", 32'(fifo1Out), 32'(e.f1));
         checkOutput("fifo2", 32'(fifo2Out), 32'(e.f2));
         checkOutput("fifo3", 32'(fifo3Out), 32'(e.f3));
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst     = 1'b1;
      validIn = 1'b0;
      pixelIn = '0;
      @(posedge clk);
      #1;
      mRow = 0;
      mCol = 0;
      lastKnown = 1'b1;
      last1 = '0; last2 = '0; last3 = '0;
      checkOutput("rstReady", 32'(readyOut), 32'd0);
      checkOutput("rstDone", 32'(frameDoneOut), 32'd0);
      checkOutput("rstFifo1", 32'(fifo1Out), 32'd0);
      checkOutput("rstFifo2", 32'(fifo2Out), 32'd0);
      checkOutput("rstFifo3", 32'(fifo3Out), 32'd0);
   endtask

   task automatic streamFrame(input int base, input int count);
      for (int i = 0; i < count; i++) applyStimulus(1'b1, DW'(base + i));
   endtask

   int doneSeen;

   // Independent tally of frame_done pulses during the first full frame
   always @(posedge clk) if (frameDoneOut) doneSeen++;

   initial begin
      rst = 1'b1; validIn = 1'b0; pixelIn = '0;
      mRow = 0; mCol = 0; doneSeen = 0;
      lastKnown = 1'b0; last1 = '0; last2 = '0; last3 = '0;
      doReset();

      // Frame 0..15 with a three-cycle stall after pixel 9
      streamFrame(0, 10);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0);
      streamFrame(10, 6);
      applyStimulus(1'b0, '0);
      checkOutput("donePulses", 32'(doneSeen), 32'd1);

      // Two frames back-to-back, the second one directly after the first
      streamFrame(20, 16);
      streamFrame(100, 16);

      // Mid-frame reset, then a fresh frame
      streamFrame(200, 11);
      doReset();
      streamFrame(50, 16);

      // Random pixels with random stalls
      for (int i = 0; i < 48; i++) begin
         if ($urandom_range(0, 3) == 0) applyStimulus(1'b0, '0);
         applyStimulus(1'b1, DW'($urandom_range(0, 255)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
